// File: rtl/pc_pkg.sv
// Processor-wide constants shared by the fetch-stage program counter.
package pc_pkg;

  localparam int unsigned XLEN            = 32;
  localparam logic [XLEN-1:0] PC_RESET_VECTOR = 32'h0000_0000;

endpackage : pc_pkg

// File: rtl/pc.sv
// Fetch-stage program counter: enable-gated register with synchronous reset.
// The next-PC mux lives outside; en is the hazard unit's stall hook.
module pc
  import pc_pkg::*;
#(
  parameter int unsigned           WIDTH        = XLEN,
  parameter logic [WIDTH-1:0]      RESET_VECTOR = WIDTH'(PC_RESET_VECTOR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] PCNext,
  output logic [WIDTH-1:0] PC_cur
);

  logic [WIDTH-1:0] pc_q;

  // Reset wins over a simultaneous load; values are stored bit-exact.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_VECTOR;
    end else if (en) begin
      pc_q <= PCNext;
    end
  end

  assign PC_cur = pc_q;

endmodule : pc

// File: tb/tb_pc.sv
// Directed bench for the program counter: expected values are queued as
// stimulus is driven and popped when the registered output is sampled.
module tb_pc;
  import pc_pkg::*;

  logic            clk;
  logic            reset;
  logic            en;
  logic [XLEN-1:0] PCNext;
  logic [XLEN-1:0] PC_cur;

  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] model_pc;
  int unsigned     checks;
  int unsigned     errors;

  pc #(
    .WIDTH       (XLEN),
    .RESET_VECTOR(PC_RESET_VECTOR)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .PCNext(PCNext),
    .PC_cur(PC_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare the current output against an explicit value.
  task automatic check_now(input string tag, input logic [XLEN-1:0] expv);
    checks++;
    assert (PC_cur === expv) else begin
      errors++;
      $error("FAIL %s: PC_cur=%h expected=%h", tag, PC_cur, expv);
    end
  endtask

  // Pop the oldest scoreboard entry and compare it with the output.
  task automatic check_pop(input string tag);
    logic [XLEN-1:0] expv;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: scoreboard empty, PC_cur=%h expected=<entry>", tag, PC_cur);
    end else begin
      expv = exp_q.pop_front();
      check_now(tag, expv);
    end
  endtask

  // Drive one edge's worth of inputs at the falling edge, queue the result,
  // then sample 1 time unit after the rising edge.
  task automatic step(input string tag, input logic r, input logic e,
                      input logic [XLEN-1:0] nxt);
    @(negedge clk);
    reset  = r;
    en     = e;
    PCNext = nxt;
    if (r)      model_pc = PC_RESET_VECTOR;
    else if (e) model_pc = nxt;
    exp_q.push_back(model_pc);
    @(posedge clk);
    #1;
    check_pop(tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    en     = 1'b0;
    PCNext = '0;
    model_pc = '0;

    step("reset",          1'b1, 1'b0, 32'h0F5A_F03C);
    step("reset_priority", 1'b1, 1'b1, 32'h0F5A_F038);
    step("load0",          1'b0, 1'b1, 32'h0F5A_F03C);
    step("load1",          1'b0, 1'b1, 32'h0F5A_F038);
    step("load2",          1'b0, 1'b1, 32'h0F5A_F03C);
    step("load_unaligned", 1'b0, 1'b1, 32'h0F5A_F039);
    step("load_pre_stall", 1'b0, 1'b1, 32'h0F5A_F038);
    for (int i = 0; i < 3; i++)
      step("stall_hold",   1'b0, 1'b0, 32'h1234_5678);
    step("stall_release",  1'b0, 1'b1, 32'h1234_5678);
    step("run",            1'b0, 1'b1, 32'h0F5A_F03C);
    step("mid_reset",      1'b1, 1'b1, 32'hDEAD_BEEF);
    step("post_reset",     1'b0, 1'b1, 32'h0000_0004);
    step("max_value",      1'b0, 1'b1, 32'hFFFF_FFFF);

    // Long stall with a changing PCNext on every edge.
    for (int i = 0; i < 5; i++)
      step("long_stall",   1'b0, 1'b0, $urandom());

    // Toggle PCNext between edges: output must stay put until the edge,
    // then capture only the last value present.
    @(negedge clk);
    reset = 1'b0;
    en    = 1'b1;
    PCNext = 32'hAAAA_0000;
    #1 check_now("glitch_stable0", model_pc);
    PCNext = 32'h5555_1111;
    #1 check_now("glitch_stable1", model_pc);
    PCNext = 32'h0000_2222;
    #1 check_now("glitch_stable2", model_pc);
    PCNext = 32'h0BAD_C0DE;
    model_pc = 32'h0BAD_C0DE;
    exp_q.push_back(model_pc);
    @(posedge clk);
    #1 check_pop("glitch_capture");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: sim_time=%0t expected=<finish>", $time);
    $fatal(1, "timeout");
  end

endmodule : tb_pc
